// File: rtl/sprite_pkg.sv
// Shared types and constants for the Mario sprite fetch / hit-test slice.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_X   = 3'd1,
    RD_Y   = 3'd2,
    RD_F   = 3'd3,
    WAIT   = 3'd4,
    COMMIT = 3'd5
  } state_e;

  localparam int X_OFS = 0;
  localparam int Y_OFS = 1;
  localparam int F_OFS = 2;

  localparam int PIX_W         = 10;
  localparam int GLYPH_FRAME_W = 5;

endpackage

// File: rtl/sprite_hit_test.sv
// Registered sprite box compare and glyph-local coordinate subtract.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        active,
  input  logic [DATA_WIDTH-1:0]       x,
  input  logic [DATA_WIDTH-1:0]       y,
  input  logic [GLYPH_FRAME_W-1:0]    frame,
  input  logic                        flip,
  input  logic                        pix_valid,
  input  logic [PIX_W-1:0]            hcount,
  input  logic [PIX_W-1:0]            vcount,
  output logic                        sprite_hit,
  output logic [$clog2(SPRITE_W)-1:0] glyph_x,
  output logic [$clog2(SPRITE_H)-1:0] glyph_y,
  output logic [GLYPH_FRAME_W-1:0]    glyph_frame
);

  localparam int GX_W = $clog2(SPRITE_W);
  localparam int GY_W = $clog2(SPRITE_H);

  logic [DATA_WIDTH:0] hx, vy, x_lo, x_hi, y_lo, y_hi;
  logic                hit;
  logic [GX_W-1:0]     dx;
  logic [GY_W-1:0]     dy;

  // One extra bit so a box near the top of the address range never wraps.
  always_comb begin
    hx   = {{(DATA_WIDTH + 1 - PIX_W){1'b0}}, hcount};
    vy   = {{(DATA_WIDTH + 1 - PIX_W){1'b0}}, vcount};
    x_lo = {1'b0, x};
    y_lo = {1'b0, y};
    x_hi = x_lo + (DATA_WIDTH + 1)'(SPRITE_W);
    y_hi = y_lo + (DATA_WIDTH + 1)'(SPRITE_H);
    hit  = pix_valid && active && (hx >= x_lo) && (hx < x_hi) &&
           (vy >= y_lo) && (vy < y_hi);
    dx   = hcount[GX_W-1:0] - x[GX_W-1:0];
    dy   = vcount[GY_W-1:0] - y[GY_W-1:0];
    if (flip) dx = ~dx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_hit <= 1'b0;
      glyph_x    <= '0;
      glyph_y    <= '0;
    end else begin
      sprite_hit <= hit;
      glyph_x    <= hit ? dx : '0;
      glyph_y    <= hit ? dy : '0;
    end
  end

  assign glyph_frame = frame;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Per-frame Mario sprite state fetch from BRAM port B plus pixel hit test.
// Build option: SPRITE_MIRROR_EN makes frame-word bit 15 a horizontal flip flag.
module mario_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h1000,
  parameter int                  SPRITE_W   = 32,
  parameter int                  SPRITE_H   = 32,
  parameter int                  NUM_FRAMES = 21
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_we,
  input  logic [DATA_WIDTH-1:0]       mem_q,
  input  logic                        pix_valid,
  input  logic [PIX_W-1:0]            hcount,
  input  logic [PIX_W-1:0]            vcount,
  output logic                        sprite_hit,
  output logic [$clog2(SPRITE_W)-1:0] glyph_x,
  output logic [$clog2(SPRITE_H)-1:0] glyph_y,
  output logic [GLYPH_FRAME_W-1:0]    glyph_frame,
  output logic                        state_valid,
  output logic                        fetch_busy,
  output logic [2:0]                  state_dbg
);

  state_e state, state_next;

  logic [DATA_WIDTH-1:0]    sh_x, sh_y, sh_frame;
  logic [DATA_WIDTH-1:0]    act_x, act_y;
  logic [GLYPH_FRAME_W-1:0] act_frame;
  logic                     act_flip;
  logic [DATA_WIDTH-1:0]    frame_raw;
  logic [GLYPH_FRAME_W-1:0] frame_clamped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // frame_start outside IDLE is dropped, never queued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = RD_X;
      RD_X:    state_next = RD_Y;
      RD_Y:    state_next = RD_F;
      RD_F:    state_next = WAIT;
      WAIT:    state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fetch_busy = (state != IDLE);
  assign mem_we     = 1'b0;
  assign state_dbg  = state;

  // Address is registered off the next state so it is valid during RD_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= BASE_ADDR;
    end else begin
      case (state_next)
        RD_X:    mem_addr <= BASE_ADDR + ADDR_WIDTH'(X_OFS);
        RD_Y:    mem_addr <= BASE_ADDR + ADDR_WIDTH'(Y_OFS);
        RD_F:    mem_addr <= BASE_ADDR + ADDR_WIDTH'(F_OFS);
        default: mem_addr <= mem_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_frame <= '0;
    end else begin
      if (state == RD_Y) sh_x     <= mem_q;
      if (state == RD_F) sh_y     <= mem_q;
      if (state == WAIT) sh_frame <= mem_q;
    end
  end

`ifdef SPRITE_MIRROR_EN
  assign frame_raw = {1'b0, sh_frame[DATA_WIDTH-2:0]};
`else
  assign frame_raw = sh_frame;
`endif

  assign frame_clamped = (frame_raw >= DATA_WIDTH'(NUM_FRAMES)) ? '0
                                                                : frame_raw[GLYPH_FRAME_W-1:0];

  // All active fields change on the same edge so no torn state reaches the pixel path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x       <= '0;
      act_y       <= '0;
      act_frame   <= '0;
      state_valid <= 1'b0;
    end else if (state == COMMIT) begin
      act_x       <= sh_x;
      act_y       <= sh_y;
      act_frame   <= frame_clamped;
      state_valid <= 1'b1;
    end
  end

`ifdef SPRITE_MIRROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                act_flip <= 1'b0;
    else if (state == COMMIT)  act_flip <= sh_frame[DATA_WIDTH-1];
  end
`else
  assign act_flip = 1'b0;
`endif

  sprite_hit_test #(
    .DATA_WIDTH (DATA_WIDTH),
    .SPRITE_W   (SPRITE_W),
    .SPRITE_H   (SPRITE_H)
  ) u_hit (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (state_valid),
    .x           (act_x),
    .y           (act_y),
    .frame       (act_frame),
    .flip        (act_flip),
    .pix_valid   (pix_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .sprite_hit  (sprite_hit),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_frame (glyph_frame)
  );

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Directed bench for mario_sprite_fetch: fetch timing, hit box edges, clamp, reset abort.
module tb_mario_sprite_fetch;

  localparam int W = 11;  // {hit, glyph_x, glyph_y}

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_q;
  logic        pix_valid;
  logic [9:0]  hcount, vcount;
  logic        sprite_hit;
  logic [4:0]  glyph_x, glyph_y, glyph_frame;
  logic        state_valid, fetch_busy;
  logic [2:0]  state_dbg;

  logic [15:0] mem_tbl [0:3];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  mario_sprite_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_q       (mem_q),
    .pix_valid   (pix_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .sprite_hit  (sprite_hit),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_frame (glyph_frame),
    .state_valid (state_valid),
    .fetch_busy  (fetch_busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read BRAM model
  always_ff @(posedge clk)
    mem_q <= (mem_addr[15:2] == 14'h0400) ? mem_tbl[mem_addr[1:0]] : 16'hDEAD;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: all drives and samples happen on the falling edge
  task automatic apply_pix(input logic [9:0] h, input logic [9:0] v, input logic pv,
                           input logic eh, input logic [4:0] egx, input logic [4:0] egy);
    logic [W-1:0] e;
    @(negedge clk);
    hcount = h; vcount = v; pix_valid = pv;
    exp_q.push_back({eh, egx, egy});
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("pix h=%0d v=%0d hit", h, v), int'(sprite_hit), int'(e[10]));
    chk($sformatf("pix h=%0d v=%0d gx", h, v), int'(glyph_x), int'(e[9:5]));
    chk($sformatf("pix h=%0d v=%0d gy", h, v), int'(glyph_y), int'(e[4:0]));
  endtask

  task automatic do_fetch(input logic [15:0] x, input logic [15:0] y, input logic [15:0] f,
                          input logic [4:0] exp_frame, input bit repulse);
    mem_tbl[0] = x; mem_tbl[1] = y; mem_tbl[2] = f;
    pix_valid = 1'b0;
    @(negedge clk); frame_start = 1'b1;                  // cycle 0
    @(negedge clk); frame_start = 1'b0;                  // cycle 1
    chk("addr c1", int'(mem_addr), 32'h1000);
    chk("busy c1", int'(fetch_busy), 1);
    @(negedge clk);                                      // cycle 2
    chk("addr c2", int'(mem_addr), 32'h1001);
    @(negedge clk);                                      // cycle 3
    chk("addr c3", int'(mem_addr), 32'h1002);
    if (repulse) frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;                  // cycle 4
    chk("addr c4 hold", int'(mem_addr), 32'h1002);
    @(negedge clk);                                      // cycle 5
    chk("busy c5", int'(fetch_busy), 1);
    @(negedge clk);                                      // cycle 6
    chk("busy c6", int'(fetch_busy), 0);
    chk("state_valid c6", int'(state_valid), 1);
    chk("glyph_frame c6", int'(glyph_frame), int'(exp_frame));
    @(negedge clk);                                      // cycle 7
    chk("busy c7", int'(fetch_busy), 0);
    chk("addr c7 hold", int'(mem_addr), 32'h1002);
  endtask

  typedef struct {
    logic [9:0] h, v;
    logic       pv, hit;
    logic [4:0] gx, gy;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{h:10'd100, v:10'd350, pv:1'b1, hit:1'b1, gx:5'd0,  gy:5'd0};
    vecs[1] = '{h:10'd131, v:10'd381, pv:1'b1, hit:1'b1, gx:5'd31, gy:5'd31};
    vecs[2] = '{h:10'd99,  v:10'd350, pv:1'b1, hit:1'b0, gx:5'd0,  gy:5'd0};
    vecs[3] = '{h:10'd132, v:10'd350, pv:1'b1, hit:1'b0, gx:5'd0,  gy:5'd0};
    vecs[4] = '{h:10'd115, v:10'd360, pv:1'b1, hit:1'b1, gx:5'd15, gy:5'd10};
    vecs[5] = '{h:10'd115, v:10'd360, pv:1'b0, hit:1'b0, gx:5'd0,  gy:5'd0};
    vecs[6] = '{h:10'd100, v:10'd349, pv:1'b1, hit:1'b0, gx:5'd0,  gy:5'd0};
    vecs[7] = '{h:10'd100, v:10'd382, pv:1'b1, hit:1'b0, gx:5'd0,  gy:5'd0};
    vecs[8] = '{h:10'd131, v:10'd350, pv:1'b1, hit:1'b1, gx:5'd31, gy:5'd0};
    vecs[9] = '{h:10'd107, v:10'd373, pv:1'b1, hit:1'b1, gx:5'd7,  gy:5'd23};

    for (int i = 0; i < 4; i++) mem_tbl[i] = 16'h0;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; hcount = '0; vcount = '0;
    repeat (3) @(negedge clk);
    chk("rst addr", int'(mem_addr), 32'h1000);
    chk("rst we", int'(mem_we), 0);
    chk("rst busy", int'(fetch_busy), 0);
    chk("rst valid", int'(state_valid), 0);
    chk("rst hit", int'(sprite_hit), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in cycle 3 of a fetch aborts it
    mem_tbl[0] = 16'd100; mem_tbl[1] = 16'd350; mem_tbl[2] = 16'd4;
    frame_start = 1'b1;                                  // cycle 0
    @(negedge clk); frame_start = 1'b0;                  // cycle 1
    @(negedge clk);                                      // cycle 2
    @(negedge clk);                                      // cycle 3
    chk("pre-abort addr", int'(mem_addr), 32'h1002);
    rst_n = 1'b0;
    #1;
    chk("abort addr", int'(mem_addr), 32'h1000);
    chk("abort busy", int'(fetch_busy), 0);
    chk("abort valid", int'(state_valid), 0);
    chk("abort frame", int'(glyph_frame), 0);
    chk("abort hit", int'(sprite_hit), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) apply_pix(10'd100, 10'd350, 1'b1, 1'b0, 5'd0, 5'd0);
    chk("abort valid later", int'(state_valid), 0);
    chk("abort busy later", int'(fetch_busy), 0);

    // main fetch and hit box table
    do_fetch(16'd100, 16'd350, 16'd0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      apply_pix(vecs[i].h, vecs[i].v, vecs[i].pv, vecs[i].hit, vecs[i].gx, vecs[i].gy);

    // frame clamp boundaries
    do_fetch(16'd100, 16'd350, 16'd25, 5'd0, 1'b0);
    do_fetch(16'd100, 16'd350, 16'd20, 5'd20, 1'b0);
    do_fetch(16'd100, 16'd350, 16'd21, 5'd0, 1'b0);

    // re-pulse in cycle 3 is ignored; new position lands on schedule
    do_fetch(16'd1000, 16'd0, 16'd7, 5'd7, 1'b1);
    apply_pix(10'd1023, 10'd0,  1'b1, 1'b1, 5'd23, 5'd0);
    apply_pix(10'd999,  10'd5,  1'b1, 1'b0, 5'd0,  5'd0);
    apply_pix(10'd1000, 10'd31, 1'b1, 1'b1, 5'd0,  5'd31);
    apply_pix(10'd1000, 10'd32, 1'b1, 1'b0, 5'd0,  5'd0);

    // bit 15 of the frame word
`ifdef SPRITE_MIRROR_EN
    do_fetch(16'd200, 16'd100, 16'h8005, 5'd5, 1'b0);
    apply_pix(10'd200, 10'd100, 1'b1, 1'b1, 5'd31, 5'd0);
    apply_pix(10'd210, 10'd101, 1'b1, 1'b1, 5'd21, 5'd1);
`else
    do_fetch(16'd200, 16'd100, 16'h8005, 5'd0, 1'b0);
    apply_pix(10'd200, 10'd100, 1'b1, 1'b1, 5'd0,  5'd0);
    apply_pix(10'd210, 10'd101, 1'b1, 1'b1, 5'd10, 5'd1);
`endif

    @(negedge clk); pix_valid = 1'b0;
    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mario_sprite_fetch.md
# mario_sprite_fetch

Per-frame sprite state reader and pixel hit-tester sitting between the shared data BRAM (read side, port B) and the VGA colour mux. At each frame start it fetches the Mario x position, y position and animation frame words from data memory, commits them atomically to active registers, then tests every incoming pixel coordinate against the sprite box. For each pixel it emits a registered hit flag plus the glyph-local coordinates and the frame index for the glyph ROM stage.

## Interface
- DATA_WIDTH, 16, BRAM word width
- ADDR_WIDTH, 16, BRAM address width
- BASE_ADDR, 16'h1000, address of x_pos; y_pos at +1, frame at +2
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- NUM_FRAMES, 21, valid animation positions 0..NUM_FRAMES-1
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- mem_addr  out  ADDR_WIDTH  BRAM port B address
- mem_we  out  1  BRAM port B write enable, constant 0
- mem_q  in  DATA_WIDTH  BRAM port B read data, valid 1 cycle after mem_addr
- pix_valid  in  1  active-video qualifier
- hcount  in  10  current pixel column
- vcount  in  10  current pixel row
- sprite_hit  out  1  pixel lies inside sprite box
- glyph_x  out  log2(SPRITE_W)  column within sprite
- glyph_y  out  log2(SPRITE_H)  row within sprite
- glyph_frame  out  5  committed animation frame
- state_valid  out  1  at least one fetch committed since reset
- fetch_busy  out  1  fetch sequence in progress

## Operation
- FSM states: IDLE, RD_X, RD_Y, RD_F, WAIT, COMMIT.
- IDLE + frame_start -> RD_X. RD_X -> RD_Y -> RD_F -> WAIT -> COMMIT -> IDLE unconditionally.
- mem_addr registered: BASE_ADDR in RD_X, +1 in RD_Y, +2 in RD_F; holds last value otherwise.
- Shadow capture: x from mem_q in RD_Y, y in RD_F, frame in WAIT.
- COMMIT copies all shadows to the active registers in one edge, so no torn state is visible. Sets state_valid.
- frame_start outside IDLE is ignored; no restart, no queueing.
- Frame clamp: shadow frame value >= NUM_FRAMES commits as 0.
- Hit test on active registers, all compares DATA_WIDTH+1 bits unsigned (no wrap). Condition: pix_valid && state_valid && x <= hcount < x+SPRITE_W && y <= vcount < y+SPRITE_H.
- glyph_x = hcount-x, glyph_y = vcount-y, both truncated to width. Both are 0 when not hit.
- Reset: state IDLE; mem_addr = BASE_ADDR; all shadow/active registers, sprite_hit, glyph_x, glyph_y, glyph_frame, state_valid and fetch_busy = 0.
- Reset mid-fetch discards shadows. The next frame_start performs a full fetch.

## Timing
- frame_start high in cycle 0 -> mem_addr = BASE_ADDR in cycle 1, +1 in cycle 2, +2 in cycle 3.
- fetch_busy high in cycles 1–5.
- Active registers, glyph_frame and state_valid update at the edge ending cycle 5; the new values are visible from cycle 6.
- Pixel path: one register stage. sprite_hit/glyph_* for (hcount, vcount, pix_valid) sampled in cycle n appear in cycle n+1.
- A commit during active video affects the hit test from the next cycle. Upstream is expected to pulse frame_start only in blanking.

## Configuration
- SPRITE_MIRROR_EN defined: bit 15 of the frame word is a horizontal flip flag, committed with the frame. When flip is set, glyph_x = SPRITE_W-1-(hcount-x). The clamp check uses bits [14:0] only.
- Not defined: bit 15 is treated as part of the frame value, and glyph_x is never mirrored.

## Structure
- Shared package sprite_pkg:
  - FSM state enum.
  - Address offsets X_OFS=0, Y_OFS=1, F_OFS=2.
  - Pixel coordinate width (10).
  - Glyph frame width (5).
- Sub-module sprite_hit_test: the registered compare/subtract stage, taking the active x/y/frame(/flip) and pixel inputs.

## Test plan
- Memory x=100, y=350, frame=0; pulse frame_start -> mem_addr 16'h1000/1001/1002 in cycles 1/2/3; state_valid rises in cycle 6; fetch_busy high cycles 1–5.
- After that commit: hcount=100, vcount=350, pix_valid=1 -> next cycle sprite_hit=1, glyph_x=0, glyph_y=0. hcount=131, vcount=381 -> hit with 31/31. hcount=99 or 132 -> hit=0.
- Memory frame=25 -> glyph_frame=0 after commit. frame=20 -> glyph_frame=20.
- frame_start re-pulsed in cycle 3 -> ignored; exactly three reads occur; commit still lands in cycle 5.
- rst_n low in cycle 3 of a fetch -> all outputs 0 immediately, state_valid stays 0, hit never asserts until a new fetch completes.
- With SPRITE_MIRROR_EN, frame word 16'h8005 -> glyph_frame=5; hcount=x -> glyph_x=31.
